draw_frame_scheduler: RTL and testbench

- Per-frame sequencer and arbiter for the VGA pixel write port, shared by four full-screen/sprite draw clients (0 = background clear, 1 = player, 2 = enemies, 3 = game-over screen).
- Each client uses the begin_draw/done level handshake and drives x/y/color/drawEn.
- The scheduler starts clients one at a time, muxes the active client onto the adapter port and reports frame completion.
- It sits between the game-logic FSM (frame tick, game_over, enable mask) and the VGA adapter.

---
 rtl/draw_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_draw_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_frame_scheduler.sv
// Per-frame sequencer/arbiter for the shared VGA pixel write port.
// Starts draw clients one at a time, muxes the active one onto the adapter, reports frame end.
module draw_frame_scheduler #(
   parameter int unsigned TIMEOUT = 100000,
   parameter int unsigned TO_W    = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        game_over,
   input  logic [2:0]  client_en,
   input  logic [3:0]  client_done,
   input  logic [31:0] client_x,
   input  logic [27:0] client_y,
   input  logic [11:0] client_color,
   input  logic [3:0]  client_plot,
   output logic [3:0]  begin_draw,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_color,
   output logic        vga_plot,
   output logic        busy,
   output logic        frame_done,
   output logic        timeout_err,
   output logic        overrun_err
);

   localparam int unsigned NCLI = 4;
   localparam int unsigned XW   = 8;
   localparam int unsigned YW   = 7;
   localparam int unsigned CW   = 3;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LATCH   = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_NEXT    = 3'd5;
   localparam logic [2:0] S_FINISH  = 3'd6;

   logic [2:0]      state_q, state_d;
   logic [3:0]      list_q, list_d;
   logic [1:0]      cur_q, cur_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]      begin_draw_q, begin_draw_d;
   logic [XW-1:0]   vga_x_q, vga_x_d;
   logic [YW-1:0]   vga_y_q, vga_y_d;
   logic [CW-1:0]   vga_color_q, vga_color_d;
   logic            vga_plot_q, vga_plot_d;
   logic            busy_q, busy_d;
   logic            frame_done_q, frame_done_d;
   logic            timeout_err_q, timeout_err_d;
   logic            overrun_err_q, overrun_err_d;

   logic [3:0]      list_nx;
   logic [XW-1:0]   cx [NCLI];
   logic [YW-1:0]   cy [NCLI];
   logic [CW-1:0]   cc [NCLI];

   // Lowest set bit of a client mask; clients are served in ascending order.
   function automatic logic [1:0] lowest_idx(input logic [3:0] m);
      lowest_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) lowest_idx = 2'(i);
      end
   endfunction

   always_comb begin
      for (int i = 0; i < NCLI; i++) begin
         cx[i] = client_x[i*XW +: XW];
         cy[i] = client_y[i*YW +: YW];
         cc[i] = client_color[i*CW +: CW];
      end
   end

   always_comb begin
      state_d       = state_q;
      list_d        = list_q;
      cur_d         = cur_q;
      to_cnt_d      = to_cnt_q;
      begin_draw_d  = begin_draw_q;
      vga_x_d       = vga_x_q;
      vga_y_d       = vga_y_q;
      vga_color_d   = vga_color_q;
      vga_plot_d    = 1'b0;
      busy_d        = busy_q;
      frame_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
      overrun_err_d = overrun_err_q | (frame_tick & (state_q != S_IDLE));
      list_nx       = list_q & ~(4'b0001 << cur_q);

      case (state_q)
         S_IDLE: begin
            busy_d = frame_tick;
            if (frame_tick) state_d = S_LATCH;
         end
         S_LATCH: begin
            list_d  = game_over ? 4'b1000 : {1'b0, client_en};
            cur_d   = lowest_idx(list_d);
            state_d = (list_d == 4'b0000) ? S_FINISH : S_START;
         end
         S_START: begin
            // A done left over from a previous grant must clear before we start this client.
            if (!client_done[cur_q]) begin
               begin_draw_d = 4'b0001 << cur_q;
               to_cnt_d     = '0;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            vga_x_d     = cx[cur_q];
            vga_y_d     = cy[cur_q];
            vga_color_d = cc[cur_q];
            vga_plot_d  = client_plot[cur_q];
            to_cnt_d    = to_cnt_q + TO_W'(1);
            if (client_done[cur_q]) begin
               begin_draw_d = 4'b0000;
               state_d      = S_RELEASE;
            end else if (to_cnt_q == TO_LAST) begin
               begin_draw_d  = 4'b0000;
               timeout_err_d = 1'b1;
               state_d       = S_NEXT;
            end
         end
         S_RELEASE: begin
            if (!client_done[cur_q]) state_d = S_NEXT;
         end
         S_NEXT: begin
            list_d  = list_nx;
            cur_d   = lowest_idx(list_nx);
            state_d = (list_nx == 4'b0000) ? S_FINISH : S_START;
         end
         S_FINISH: begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         list_q        <= '0;
         cur_q         <= '0;
         to_cnt_q      <= '0;
         begin_draw_q  <= '0;
         vga_x_q       <= '0;
         vga_y_q       <= '0;
         vga_color_q   <= '0;
         vga_plot_q    <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         list_q        <= list_d;
         cur_q         <= cur_d;
         to_cnt_q      <= to_cnt_d;
         begin_draw_q  <= begin_draw_d;
         vga_x_q       <= vga_x_d;
         vga_y_q       <= vga_y_d;
         vga_color_q   <= vga_color_d;
         vga_plot_q    <= vga_plot_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         timeout_err_q <= timeout_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign begin_draw  = begin_draw_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_color   = vga_color_q;
   assign vga_plot    = vga_plot_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;
   assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_draw_frame_scheduler.sv
// Randomized bench for draw_frame_scheduler: behavioural clients plus a frame-level
// model of start order, grant length, pixel pass-through and sticky flags.
module tb_draw_frame_scheduler;

   localparam int unsigned TIMEOUT = 50;
   localparam int unsigned TO_W    = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        game_over;
   logic [2:0]  client_en;
   logic [3:0]  client_done;
   logic [31:0] client_x;
   logic [27:0] client_y;
   logic [11:0] client_color;
   logic [3:0]  client_plot;
   logic [3:0]  begin_draw;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_color;
   logic        vga_plot;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;
   logic        overrun_err;

   draw_frame_scheduler #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
      .client_en(client_en), .client_done(client_done), .client_x(client_x),
      .client_y(client_y), .client_color(client_color), .client_plot(client_plot),
      .begin_draw(begin_draw), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
      .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done),
      .timeout_err(timeout_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Client behaviour and reference model state
   int          lat   [4];
   bit          never [4];
   int          cnt   [4];
   int          exp_q [$];
   bit          exp_to, exp_ovr, fix3;
   logic [3:0]  prev_bd, prev_p;
   logic [31:0] prev_x;
   logic [27:0] prev_y;
   logic [11:0] prev_c;
   logic [7:0]  exp_vx;
   logic [6:0]  exp_vy;
   logic [2:0]  exp_vc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: sample outputs after the edge, check them, then advance the client models.
   task automatic step();
      int idx;
      @(posedge clk);
      #1;
      check("onehot", 32'($countones(begin_draw) <= 1), 1);
      if (prev_bd != 4'b0000) begin
         idx = 0;
         for (int i = 3; i >= 0; i--) if (prev_bd[i]) idx = i;
         exp_vx = prev_x[idx*8 +: 8];
         exp_vy = prev_y[idx*7 +: 7];
         exp_vc = prev_c[idx*3 +: 3];
         check("vga_plot", vga_plot, prev_p[idx]);
      end else begin
         check("vga_plot_idle", vga_plot, 0);
      end
      check("vga_x", vga_x, exp_vx);
      check("vga_y", vga_y, exp_vy);
      check("vga_color", vga_color, exp_vc);
      for (int i = 0; i < 4; i++) begin
         if (begin_draw[i] && !prev_bd[i]) begin
            cnt[i] = 0;
            if (exp_q.size() == 0) check("start_order", i, 99);
            else check("start_order", i, exp_q.pop_front());
         end
         if (!begin_draw[i] && prev_bd[i])
            check("hold_len", cnt[i], never[i] ? TIMEOUT : lat[i]);
         if (begin_draw[i]) begin
            cnt[i]++;
            if (!never[i] && cnt[i] >= lat[i]) client_done[i] = 1'b1;
         end else begin
            client_done[i] = 1'b0;
         end
      end
      prev_bd      = begin_draw;
      client_x     = $urandom;
      client_y     = 28'($urandom);
      client_color = 12'($urandom);
      client_plot  = 4'($urandom);
      if (fix3) begin
         client_x[31:24]    = 8'd159;
         client_y[27:21]    = 7'd119;
         client_color[11:9] = 3'b101;
         client_plot[3]     = 1'b1;
      end
      prev_x = client_x;
      prev_y = client_y;
      prev_c = client_color;
      prev_p = client_plot;
   endtask

   task automatic run_frame(input logic go, input logic [2:0] en, input bit do_ovr);
      int n;
      int ovr_wait;
      bit ovr_pend;
      game_over = go;
      client_en = en;
      if (go) begin
         exp_q.push_back(3);
         if (never[3]) exp_to = 1'b1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
               exp_q.push_back(i);
               if (never[i]) exp_to = 1'b1;
            end
         end
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("busy_set", busy, 1);
      n        = 0;
      ovr_pend = do_ovr;
      ovr_wait = $urandom_range(0, 4);
      while (frame_done !== 1'b1 && n < 1000) begin
         if (ovr_pend && begin_draw != 4'b0000) begin
            if (ovr_wait == 0) begin
               frame_tick = 1'b1;
               exp_ovr    = 1'b1;
               ovr_pend   = 1'b0;
            end else begin
               ovr_wait--;
            end
         end
         step();
         frame_tick = 1'b0;
         n++;
         // Mid-frame changes must not affect the frame already latched.
         if (n == 1) begin
            game_over = 1'($urandom);
            client_en = 3'($urandom);
         end
         check("busy_hold", busy, 1);
      end
      check("frame_done", frame_done, 1);
      if (!go && en == 3'b000) check("empty_latency", 32'((n + 1) <= 3), 1);
      check("starts_left", exp_q.size(), 0);
      exp_q.delete();
      step();
      check("busy_clear", busy, 0);
      check("fd_single", frame_done, 0);
      check("timeout_err", timeout_err, exp_to);
      check("overrun_err", overrun_err, exp_ovr);
      repeat (2) begin
         step();
         check("idle_no_start", begin_draw, 0);
      end
   endtask

   task automatic set_clients(input int l, input bit nv);
      for (int i = 0; i < 4; i++) begin
         lat[i]   = l;
         never[i] = nv;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; frame_tick = 1'b0; game_over = 1'b0; client_en = 3'b000;
      client_done = '0; client_x = '0; client_y = '0; client_color = '0; client_plot = '0;
      prev_bd = '0; prev_p = '0; prev_x = '0; prev_y = '0; prev_c = '0;
      exp_vx = '0; exp_vy = '0; exp_vc = '0; exp_to = 1'b0; exp_ovr = 1'b0; fix3 = 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      set_clients(10, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_begin_draw", begin_draw, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_overrun", overrun_err, 0);
      check("rst_vga_plot", vga_plot, 0);
      check("rst_vga_x", vga_x, 0);
      @(negedge clk);
      reset = 1'b0;

      // All three normal clients, fixed 10-cycle done latency
      run_frame(1'b0, 3'b111, 1'b0);

      // Game-over frame with fixed client 3 pixel
      fix3 = 1'b1;
      run_frame(1'b1, 3'b111, 1'b0);
      fix3 = 1'b0;

      // Empty list
      run_frame(1'b0, 3'b000, 1'b0);

      // Client 0 never finishes
      set_clients(5, 1'b0);
      never[0] = 1'b1;
      run_frame(1'b0, 3'b011, 1'b0);
      never[0] = 1'b0;

      // Overrun tick during a busy frame
      set_clients(10, 1'b0);
      run_frame(1'b0, 3'b111, 1'b1);

      // Reset while client 1 is running
      set_clients(15, 1'b0);
      game_over = 1'b0;
      client_en = 3'b011;
      exp_q.push_back(0);
      exp_q.push_back(1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n = 0;
      while (begin_draw[1] !== 1'b1 && n < 500) begin
         step();
         n++;
      end
      check("reach_client1", begin_draw[1], 1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("pre_rst_overrun", overrun_err, 1);
      check("pre_rst_timeout", timeout_err, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_begin_draw", begin_draw, 0);
      check("rst_mid_vga_plot", vga_plot, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_timeout", timeout_err, 0);
      check("rst_mid_overrun", overrun_err, 0);
      #2 reset = 1'b0;
      exp_q.delete();
      prev_bd = '0;
      client_done = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      exp_vx = '0; exp_vy = '0; exp_vc = '0;
      exp_to = 1'b0; exp_ovr = 1'b0;
      run_frame(1'b0, 3'b111, 1'b0);

      // Randomized frames
      repeat (40) begin
         for (int i = 0; i < 4; i++) begin
            lat[i]   = $urandom_range(1, 20);
            never[i] = ($urandom_range(0, 7) == 0);
         end
         run_frame(1'($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 3)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
